// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, response error codes,
// FSM state type, and the request legality / store-lane helper functions.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  // An illegal funct3 outranks misalignment, so a bad store width reports 10 even when unaligned.
  function automatic logic [1:0] check_request(input logic       is_store,
                                               input logic [2:0] funct3,
                                               input logic [1:0] offset);
    logic legal;
    logic misaligned;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !is_store;
      default:          legal = 1'b0;
    endcase
    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && offset[0]) ||
                 (funct3 == F3_W && offset != 2'b00);
    if (!legal)          return ERR_FUNCT3;
    else if (misaligned) return ERR_MISALIGN;
    else                 return ERR_OK;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B:    return 4'b0001 << offset;
      F3_H:    return 4'b0011 << {offset[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory read word and sign- or zero-extends it
// according to the load funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_word[8*offset +: 8];
    half_sel = offset[1] ? rdata_word[31:16] : rdata_word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'b0, byte_sel};
      F3_HU:   result = {16'b0, half_sel};
      default: result = rdata_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: takes one load/store at a time, issues a word access with byte
// strobes, waits (bounded) for load data, and returns an aligned result or an error code.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        offset_q, offset_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       load_result;
  logic [1:0]        req_check;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

  lsu_load_align u_align (
    .rdata_word (mem_rdata),
    .offset     (offset_q),
    .funct3     (funct3_q),
    .result     (load_result)
  );

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = 4'b0000;
    mem_wdata_d = mem_wdata_q;
    req_check   = check_request(req_is_store, req_funct3, req_addr[1:0]);

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          offset_d   = req_addr[1:0];
          if (req_check != ERR_OK) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_check;
            rsp_rdata_d = '0;
          end else begin
            state_d     = S_ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = req_addr[ADDR_W+1:2];
            mem_wstrb_d = req_is_store ? store_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
            mem_wdata_d = req_is_store ? store_data(req_funct3, req_wdata) : '0;
          end
        end
      end
      S_ISSUE: begin
        if (is_store_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = '0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      // Counter value equals the number of silent WAIT cycles already spent.
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = load_result;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of directed vectors, randomized requests
// against a transaction-level reference model, and hand-written timeout/reset sequences.
module tb_load_store_unit;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_is_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_err;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_rvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid)
  );

  typedef struct {
    bit                st;
    logic [2:0]        f3;
    logic [31:0]       addr;
    logic [31:0]       wd;
    logic [31:0]       rd;
    logic [1:0]        err;
    logic [31:0]       rdata;
    logic [3:0]        strb;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] maddr;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Transaction-level model: byte lanes, replication and extension by plain arithmetic.
  function automatic void ref_model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [31:0] rd,
                                    output logic [1:0] err, output logic [31:0] rdata,
                                    output logic [3:0] strb, output logic [31:0] wdat,
                                    output logic [ADDR_W-1:0] maddr);
    int     size;
    bit     sgn;
    int     off;
    longint v;
    longint one;
    one  = 1;
    size = 0;
    sgn  = 0;
    case (f3)
      3'd0:    begin size = 1; sgn = 1; end
      3'd1:    begin size = 2; sgn = 1; end
      3'd2:    size = 4;
      3'd4:    size = 1;
      3'd5:    size = 2;
      default: size = 0;
    endcase
    off   = int'(a % 4);
    err   = 2'd0;
    rdata = '0;
    strb  = '0;
    wdat  = '0;
    maddr = ADDR_W'((a / 4) % (1 << ADDR_W));
    if (size == 0 || (st && f3 >= 3'd4)) err = 2'd2;
    else if (off % size != 0) err = 2'd1;
    else if (st) begin
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + size) strb[b] = 1'b1;
        wdat[8*b +: 8] = wd[8*(b % size) +: 8];
      end
    end else begin
      v = longint'(rd);
      v = (v >> (8 * off)) % (one << (8 * size));
      if (sgn && v >= (one << (8 * size - 1))) v = v - (one << (8 * size));
      rdata = v[31:0];
    end
  endfunction

  task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input bit respond, input int hold,
                               input logic [1:0] e_err, input logic [31:0] e_rdata,
                               input logic [3:0] e_strb, input logic [31:0] e_wdata,
                               input logic [ADDR_W-1:0] e_maddr);
    int waited, cyc, req_count, req_cyc, rsp_cyc, exp_lat;
    bit pending, got;
    logic we_s;
    logic [ADDR_W-1:0] addr_s;
    logic [3:0] strb_s;
    logic [31:0] wdata_s;
    waited = 0;
    while (!req_ready && waited < 8) begin
      tick();
      waited++;
    end
    checkOutput("req_ready before accept", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wd;
    tick();
    req_valid = 1'b0;
    cyc = 1; req_count = 0; req_cyc = 0; rsp_cyc = 0;
    pending = 0; got = 0;
    we_s = 0; addr_s = '0; strb_s = '0; wdata_s = '0;
    while (!got && cyc <= TIMEOUT + 10) begin
      mem_rvalid = pending && respond;
      mem_rdata  = rd;
      pending    = 0;
      if (mem_req) begin
        req_count++;
        req_cyc = cyc;
        we_s    = mem_we;
        addr_s  = mem_addr;
        strb_s  = mem_wstrb;
        wdata_s = mem_wdata;
        if (!st) pending = 1;
      end
      if (rsp_valid) begin
        got     = 1;
        rsp_cyc = cyc;
      end else begin
        tick();
        cyc++;
      end
    end
    mem_rvalid = 1'b0;
    if (e_err == 2'd1 || e_err == 2'd2) exp_lat = 1;
    else if (st)                        exp_lat = 2;
    else if (e_err == 2'd3)             exp_lat = TIMEOUT + 2;
    else                                exp_lat = 3;
    checkOutput("response latency", 32'(rsp_cyc), 32'(exp_lat));
    checkOutput("mem_req pulse count", 32'(req_count),
                (e_err == 2'd1 || e_err == 2'd2) ? 32'd0 : 32'd1);
    if (req_count == 1) begin
      checkOutput("mem_req cycle", 32'(req_cyc), 32'd1);
      checkOutput("mem_we", 32'(we_s), 32'(st));
      checkOutput("mem_addr", 32'(addr_s), 32'(e_maddr));
      checkOutput("mem_wstrb", 32'(strb_s), 32'(e_strb));
      if (st) checkOutput("mem_wdata", wdata_s, e_wdata);
    end
    if (!got) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      return;
    end
    checkOutput("rsp_rdata", rsp_rdata, e_rdata);
    checkOutput("rsp_err", 32'(rsp_err), 32'(e_err));
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("rsp_valid held", 32'(rsp_valid), 32'd1);
      checkOutput("rsp_rdata stable", rsp_rdata, e_rdata);
      checkOutput("rsp_err stable", 32'(rsp_err), 32'(e_err));
      checkOutput("req_ready low in RESP", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    checkOutput("req_ready low at handshake", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_valid dropped", 32'(rsp_valid), 32'd0);
    checkOutput("req_ready reasserted", 32'(req_ready), 32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, " mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]        m_err;
    logic [31:0]       m_rdata, m_wdata, r_addr, r_wd, r_rd;
    logic [3:0]        m_strb;
    logic [ADDR_W-1:0] m_maddr;
    bit                r_st;
    logic [2:0]        r_f3;

    vecs[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        2'd0, 32'h0,        4'hF, 32'hDEADBEEF, 10'd4};
    vecs[1]  = '{1'b1, 3'b000, 32'h13,  32'h000000A5, 32'h0,        2'd0, 32'h0,        4'h8, 32'hA5A5A5A5, 10'd4};
    vecs[2]  = '{1'b1, 3'b001, 32'h16,  32'h0000BEEF, 32'h0,        2'd0, 32'h0,        4'hC, 32'hBEEFBEEF, 10'd5};
    vecs[3]  = '{1'b1, 3'b000, 32'h12,  32'h1234567C, 32'h0,        2'd0, 32'h0,        4'h4, 32'h7C7C7C7C, 10'd4};
    vecs[4]  = '{1'b0, 3'b000, 32'h21,  32'h0,        32'h123480FF, 2'd0, 32'hFFFFFF80, 4'h0, 32'h0,        10'd8};
    vecs[5]  = '{1'b0, 3'b100, 32'h21,  32'h0,        32'h123480FF, 2'd0, 32'h00000080, 4'h0, 32'h0,        10'd8};
    vecs[6]  = '{1'b0, 3'b101, 32'h22,  32'h0,        32'h123480FF, 2'd0, 32'h00001234, 4'h0, 32'h0,        10'd8};
    vecs[7]  = '{1'b0, 3'b001, 32'h20,  32'h0,        32'h123480FF, 2'd0, 32'hFFFF80FF, 4'h0, 32'h0,        10'd8};
    vecs[8]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 2'd0, 32'hCAFEF00D, 4'h0, 32'h0,        10'h41};
    vecs[9]  = '{1'b0, 3'b010, 32'h6,   32'h0,        32'h0,        2'd1, 32'h0,        4'h0, 32'h0,        10'd0};
    vecs[10] = '{1'b1, 3'b001, 32'h17,  32'h0,        32'h0,        2'd1, 32'h0,        4'h0, 32'h0,        10'd0};
    vecs[11] = '{1'b0, 3'b011, 32'h20,  32'h0,        32'h0,        2'd2, 32'h0,        4'h0, 32'h0,        10'd0};
    vecs[12] = '{1'b1, 3'b100, 32'h20,  32'h0,        32'h0,        2'd2, 32'h0,        4'h0, 32'h0,        10'd0};
    vecs[13] = '{1'b0, 3'b111, 32'h3,   32'h0,        32'h0,        2'd2, 32'h0,        4'h0, 32'h0,        10'd0};

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    tick();
    tick();
    checkIdleOutputs("reset");
    rst = 1'b0;
    tick();
    checkOutput("req_ready after reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd, 1'b1, i % 3,
                    vecs[i].err, vecs[i].rdata, vecs[i].strb, vecs[i].wdata, vecs[i].maddr);
    end

    // Slow consumer: response must sit still for five cycles.
    applyStimulus(1'b0, 3'b000, 32'h21, 32'h0, 32'h123480FF, 1'b1, 5,
                  2'd0, 32'hFFFFFF80, 4'h0, 32'h0, 10'd8);

    // Memory never answers, then answers late while idle.
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 2,
                  2'd3, 32'h0, 4'h0, 32'h0, 10'h10);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("late rvalid ignored", 32'(rsp_valid), 32'd0);
    end
    mem_rvalid = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h44, 32'h0, 32'h01020304, 1'b1, 0,
                  2'd0, 32'h01020304, 4'h0, 32'h0, 10'h11);

    // Reset while waiting for load data aborts the access silently.
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkIdleOutputs("reset in WAIT");
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rvalid after reset ignored", 32'(rsp_valid), 32'd0);
    end
    mem_rvalid = 1'b0;
    checkOutput("req_ready after mid-op reset", 32'(req_ready), 32'd1);

    for (int n = 0; n < 60; n++) begin
      r_st   = bit'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      ref_model(r_st, r_f3, r_addr, r_wd, r_rd, m_err, m_rdata, m_strb, m_wdata, m_maddr);
      applyStimulus(r_st, r_f3, r_addr, r_wd, r_rd, 1'b1, int'($urandom_range(0, 2)),
                    m_err, m_rdata, m_strb, m_wdata, m_maddr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
